regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the fixed 32x32 dual-write/dual-read main register file.
- Generalises register count and data width.
- Defines write-port priority on address collision.
- Adds a per-register busy scoreboard for issue/writeback tracking, so the control unit can stall on pending results.
- Sits between the decode stage (read ports, issue) and the writeback stage (write ports).

Parameters:
- WIDTH, 32, data width of each register.
- NREG, 32, number of registers (power of two, >=4); register 0 is hardwired zero.
- AW, $clog2(NREG), address width (derived, not overridden).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous active-low reset; clears registers and scoreboard on the CLK edge where RESET=0.
- WEA  in  1  write enable, port A.
- WAA  in  AW  write address, port A.
- INA  in  WIDTH  write data, port A.
- WEB  in  1  write enable, port B.
- WAB  in  AW  write address, port B.
- INB  in  WIDTH  write data, port B.
- RAA  in  AW  read address, port A.
- RAB  in  AW  read address, port B.
- OUTA  out  WIDTH  read data, port A.
- OUTB  out  WIDTH  read data, port B.
- ISSUE  in  1  mark ISSUE_ADDR busy (destination of a newly issued instruction).
- ISSUE_ADDR  in  AW  destination register being issued.
- BUSYA  out  1  busy bit of register RAA.
- BUSYB  out  1  busy bit of register RAB.
- BUSY_CNT  out  AW+1  registered count of busy registers.

Behaviour:
- Reset: on the CLK edge with RESET=0, all registers are cleared to 0, all busy bits to 0, and BUSY_CNT to 0. Reset overrides any same-cycle write or issue. Following reset, OUTA/OUTB read 0 and BUSYA/BUSYB read 0 for every address.
- Reads: combinational, zero-cycle latency. OUTx = reg[RAx]; reads of address 0 always return 0.
- Writes: on the CLK edge, reg[WAA]<=INA if WEA, and reg[WAB]<=INB if WEB.
  - Writes to address 0 are discarded.
  - WEA&WEB with WAA==WAB: port B wins; INB is stored, never an OR of INA and INB.
- Scoreboard:
  - busy[n] next-state on each CLK edge (RESET=1), in priority order:
    1. set, if ISSUE && ISSUE_ADDR==n;
    2. else clear, if (WEA && WAA==n) || (WEB && WAB==n);
    3. else hold.
  - Issue-over-writeback: when an issue and a writeback hit the same register in the same cycle, set wins, because the new producer is outstanding.
  - busy[0] is constant 0; ISSUE to address 0 is ignored.
  - Re-issuing an already-busy register keeps it busy. Only one outstanding producer per register is tracked; a single writeback clears it.
  - A writeback to a non-busy register writes data and leaves busy at 0.
  - BUSYx = busy[RAx], combinational from the registered bits.
- BUSY_CNT: registered popcount of the next-state busy vector, so it equals the number of busy bits visible after the edge. Range 0..NREG-1.
- No X-propagation from disabled ports: when WEx=0, the WAx/INx values are don't-care.

Optional Feature:
- Macro: REGFILE_SB_FWD_EN.
- Defined: write-to-read bypass.
  - If WEB && WAB==RAx && RAx!=0, then OUTx=INB.
  - Otherwise, if WEA && WAA==RAx && RAx!=0, then OUTx=INA.
  - Otherwise OUTx=reg[RAx].
  - BUSYx reads 0 when a same-cycle writeback targets RAx and no same-cycle ISSUE targets RAx.
- Undefined: reads and BUSYx reflect only registered state; a value written this cycle is visible the next cycle.

Decomposition:
- Package regfile_pkg:
  - default WIDTH/NREG constants;
  - ZERO_REG address constant (0);
  - a function for the popcount width.
- Sub-module regfile_scoreboard (NREG, AW). It holds the busy vector, set/clear priority, BUSY_CNT, and the BUSYA/BUSYB lookups. The data array and read muxing stay in regfile_sb.

Test Plan:
- Reset then read all addresses -> OUTA=OUTB=0, BUSYA=BUSYB=0, BUSY_CNT=0. Write 0xDEADBEEF to r5, assert RESET=0 for one edge -> r5 reads 0.
- Write collision: WEA, WAA=7, INA=0x0000_00F0 and WEB, WAB=7, INB=0x0000_000F on the same edge -> next cycle RAA=7 gives OUTA=0x0000_000F. Write 0x1234 to r0 -> OUTA=0.
- Scoreboard: ISSUE r3 -> BUSY_CNT=1 and BUSYA=1 at RAA=3. ISSUE r4 -> BUSY_CNT=2. Writeback r3 via port B -> BUSYA=0, BUSY_CNT=1.
- Same-cycle ISSUE r9 and WEA to r9 with 0x55 -> r9=0x55, busy[9]=1. ISSUE r0 -> BUSY_CNT unchanged.
- With REGFILE_SB_FWD_EN: RAA=12, WEB, WAB=12, INB=0xA5A5A5A5 -> OUTA=0xA5A5A5A5 in the same cycle. Without the macro, OUTA shows the old value that cycle and 0xA5A5A5A5 the next.
- Random stress, 10k cycles: random writes, issues, resets checked against a reference model. Checks: port-B priority, r0 always 0, BUSY_CNT equals the popcount of busy.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the scoreboarded register file
// Contents:
//   DEF_WIDTH / DEF_NREG - default data width and register count
//   ZERO_REG             - address of the hardwired-zero register
//   cnt_width()          - width of a popcount over nreg busy bits
package regfile_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREG  = 32;
    localparam int ZERO_REG  = 0;
    function automatic int cnt_width(input int nreg);
        return $clog2(nreg) + 1;
    endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: write/read/issue bus of the scoreboarded register file
// Signals:
//   WEA/WAA/INA, WEB/WAB/INB - writeback ports A and B
//   RAA/RAB -> OUTA/OUTB     - combinational read ports
//   ISSUE/ISSUE_ADDR         - mark a destination register busy
//   BUSYA/BUSYB, BUSY_CNT    - scoreboard lookups and busy count
// Modports: master drives requests, slave is the register file.
interface regfile_sb_if #(
    parameter int WIDTH = regfile_pkg::DEF_WIDTH,
    parameter int NREG  = regfile_pkg::DEF_NREG
);
    localparam int AW = $clog2(NREG);
    logic             WEA;
    logic [AW-1:0]    WAA;
    logic [WIDTH-1:0] INA;
    logic             WEB;
    logic [AW-1:0]    WAB;
    logic [WIDTH-1:0] INB;
    logic [AW-1:0]    RAA;
    logic [AW-1:0]    RAB;
    logic [WIDTH-1:0] OUTA;
    logic [WIDTH-1:0] OUTB;
    logic             ISSUE;
    logic [AW-1:0]    ISSUE_ADDR;
    logic             BUSYA;
    logic             BUSYB;
    logic [AW:0]      BUSY_CNT;
    modport master (
        output WEA, WAA, INA, WEB, WAB, INB, RAA, RAB, ISSUE, ISSUE_ADDR,
        input  OUTA, OUTB, BUSYA, BUSYB, BUSY_CNT
    );
    modport slave (
        input  WEA, WAA, INA, WEB, WAB, INB, RAA, RAB, ISSUE, ISSUE_ADDR,
        output OUTA, OUTB, BUSYA, BUSYB, BUSY_CNT
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with issue-over-writeback priority
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   i_issue, i_issue_addr           - set busy for a newly issued destination
//   i_wea/i_waa, i_web/i_wab        - writebacks clear busy
//   i_raa/i_rab -> o_busya/o_busyb  - busy lookups
//   o_busy_cnt                      - registered popcount of the busy vector
// Optional: REGFILE_SB_FWD_EN hides busy for a same-cycle writeback
// that is not overridden by a same-cycle issue.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_issue,
    input  logic [AW-1:0] i_issue_addr,
    input  logic          i_wea,
    input  logic [AW-1:0] i_waa,
    input  logic          i_web,
    input  logic [AW-1:0] i_wab,
    input  logic [AW-1:0] i_raa,
    input  logic [AW-1:0] i_rab,
    output logic          o_busya,
    output logic          o_busyb,
    output logic [AW:0]   o_busy_cnt
);
    localparam int CW = cnt_width(NREG);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt;
    // Counting the next-state vector lets the registered count line up
    // with the busy bits visible after the same edge.
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt = '0;
        for (int n = 1; n < NREG; n++) begin
            if (i_issue && i_issue_addr == AW'(n))
                w_busy_nxt[n] = 1'b1;
            else if ((i_wea && i_waa == AW'(n)) || (i_web && i_wab == AW'(n)))
                w_busy_nxt[n] = 1'b0;
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
        for (int n = 0; n < NREG; n++)
            w_cnt = w_cnt + CW'(w_busy_nxt[n]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt;
        end
    end
`ifdef REGFILE_SB_FWD_EN
    logic w_wb_a, w_wb_b, w_iss_a, w_iss_b;
    assign w_wb_a  = (i_wea && i_waa == i_raa) || (i_web && i_wab == i_raa);
    assign w_wb_b  = (i_wea && i_waa == i_rab) || (i_web && i_wab == i_rab);
    assign w_iss_a = i_issue && i_issue_addr == i_raa;
    assign w_iss_b = i_issue && i_issue_addr == i_rab;
    assign o_busya = r_busy[i_raa] && !(w_wb_a && !w_iss_a);
    assign o_busyb = r_busy[i_rab] && !(w_wb_b && !w_iss_b);
`else
    assign o_busya = r_busy[i_raa];
    assign o_busyb = r_busy[i_rab];
`endif
    assign o_busy_cnt = r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised dual-write/dual-read register file with busy scoreboard
// Ports:
//   CLK   - system clock, rising edge
//   RESET - synchronous active-low reset of registers and scoreboard
//   bus   - regfile_sb_if.slave: write ports A/B, read ports A/B, issue, busy
// Register 0 reads as zero; port B wins a same-address write collision.
// Optional: REGFILE_SB_FWD_EN bypasses same-cycle write data to the reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG
) (
    input logic         CLK,
    input logic         RESET,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);
    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] w_outa;
    logic [WIDTH-1:0] w_outb;
    // B is written after A so it takes the slot on an address collision.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else begin
            if (bus.WEA && bus.WAA != AW'(ZERO_REG))
                r_regs[bus.WAA] <= bus.INA;
            if (bus.WEB && bus.WAB != AW'(ZERO_REG))
                r_regs[bus.WAB] <= bus.INB;
        end
    end
    always_comb begin
`ifdef REGFILE_SB_FWD_EN
        w_outa = (bus.RAA == AW'(ZERO_REG)) ? '0 :
                 (bus.WEB && bus.WAB == bus.RAA) ? bus.INB :
                 (bus.WEA && bus.WAA == bus.RAA) ? bus.INA : r_regs[bus.RAA];
        w_outb = (bus.RAB == AW'(ZERO_REG)) ? '0 :
                 (bus.WEB && bus.WAB == bus.RAB) ? bus.INB :
                 (bus.WEA && bus.WAA == bus.RAB) ? bus.INA : r_regs[bus.RAB];
`else
        w_outa = (bus.RAA == AW'(ZERO_REG)) ? '0 : r_regs[bus.RAA];
        w_outb = (bus.RAB == AW'(ZERO_REG)) ? '0 : r_regs[bus.RAB];
`endif
    end
    assign bus.OUTA = w_outa;
    assign bus.OUTB = w_outb;
    regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
        .clk          (CLK),
        .rst_n        (RESET),
        .i_issue      (bus.ISSUE),
        .i_issue_addr (bus.ISSUE_ADDR),
        .i_wea        (bus.WEA),
        .i_waa        (bus.WAA),
        .i_web        (bus.WEB),
        .i_wab        (bus.WAB),
        .i_raa        (bus.RAA),
        .i_rab        (bus.RAB),
        .o_busya      (bus.BUSYA),
        .o_busyb      (bus.BUSYB),
        .o_busy_cnt   (bus.BUSY_CNT)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against an array model
module tb_regfile_sb;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int vecs = 0;
    int errs = 0;
    bit model_ok = 1'b0;
    logic [31:0] m_reg [32];
    bit m_busy [32];
    regfile_sb_if #(.WIDTH(32), .NREG(32)) bus ();
    regfile_sb #(.WIDTH(32), .NREG(32)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] exp_out(input logic [4:0] ra);
        if (ra == 0) return 32'h0;
`ifdef REGFILE_SB_FWD_EN
        if (bus.WEB && bus.WAB == ra) return bus.INB;
        if (bus.WEA && bus.WAA == ra) return bus.INA;
`endif
        return m_reg[ra];
    endfunction
    function automatic logic exp_busy(input logic [4:0] ra);
`ifdef REGFILE_SB_FWD_EN
        if (((bus.WEA && bus.WAA == ra) || (bus.WEB && bus.WAB == ra)) &&
            !(bus.ISSUE && bus.ISSUE_ADDR == ra)) return 1'b0;
`endif
        return m_busy[ra];
    endfunction
    task automatic cycle(input logic rst_n,
                         input logic wea, input logic [4:0] waa, input logic [31:0] ina,
                         input logic web, input logic [4:0] wab, input logic [31:0] inb,
                         input logic iss, input logic [4:0] isa,
                         input logic [4:0] raa, input logic [4:0] rab);
        int cnt;
        @(negedge CLK);
        RESET = rst_n;
        bus.WEA = wea; bus.WAA = waa; bus.INA = ina;
        bus.WEB = web; bus.WAB = wab; bus.INB = inb;
        bus.ISSUE = iss; bus.ISSUE_ADDR = isa;
        bus.RAA = raa; bus.RAB = rab;
        #1;
        if (model_ok) begin
            chk("outa", bus.OUTA, exp_out(raa));
            chk("outb", bus.OUTB, exp_out(rab));
            chk("busya", 32'(bus.BUSYA), 32'(exp_busy(raa)));
            chk("busyb", 32'(bus.BUSYB), 32'(exp_busy(rab)));
        end
        @(posedge CLK);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
            model_ok = 1'b1;
        end else begin
            for (int n = 1; n < 32; n++) begin
                if (iss && isa == 5'(n)) m_busy[n] = 1'b1;
                else if ((wea && waa == 5'(n)) || (web && wab == 5'(n))) m_busy[n] = 1'b0;
            end
            if (wea && waa != 0) m_reg[waa] = ina;
            if (web && wab != 0) m_reg[wab] = inb;
        end
        #1;
        cnt = 0;
        foreach (m_busy[i]) cnt += int'(m_busy[i]);
        if (model_ok) chk("busy_cnt", 32'(bus.BUSY_CNT), 32'(cnt));
    endtask
    task automatic peek(input logic [4:0] raa, input logic [4:0] rab);
        @(negedge CLK);
        RESET = 1'b1;
        bus.WEA = 1'b0; bus.WEB = 1'b0; bus.ISSUE = 1'b0;
        bus.RAA = raa; bus.RAB = rab;
        #1;
    endtask
    initial begin
        bus.WEA = 0; bus.WAA = 0; bus.INA = 0; bus.WEB = 0; bus.WAB = 0; bus.INB = 0;
        bus.ISSUE = 0; bus.ISSUE_ADDR = 0; bus.RAA = 0; bus.RAB = 0;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
        peek(0, 0);
        chk("rst_cnt", 32'(bus.BUSY_CNT), 32'h0);
        cycle(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);
        peek(5, 5);
        chk("r5_written", bus.OUTA, 32'hDEADBEEF);
        cycle(0, 1, 6, 32'h1, 0, 0, 0, 1, 6, 5, 5);
        peek(5, 6);
        chk("r5_after_rst", bus.OUTA, 32'h0);
        chk("rst_over_write", bus.OUTB, 32'h0);
        chk("rst_over_issue", 32'(bus.BUSYB), 32'h0);
        cycle(1, 1, 7, 32'h0000_00F0, 1, 7, 32'h0000_000F, 0, 0, 0, 0);
        peek(7, 7);
        chk("collision_b_wins", bus.OUTA, 32'h0000_000F);
        cycle(1, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        peek(0, 0);
        chk("r0_zero", bus.OUTA, 32'h0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 3, 3, 4);
        peek(3, 4);
        chk("issue3_busy", 32'(bus.BUSYA), 32'h1);
        chk("issue3_cnt", 32'(bus.BUSY_CNT), 32'h1);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 4, 3, 4);
        peek(3, 4);
        chk("issue4_cnt", 32'(bus.BUSY_CNT), 32'h2);
        chk("issue4_busy", 32'(bus.BUSYB), 32'h1);
        cycle(1, 0, 0, 0, 1, 3, 32'h33, 0, 0, 3, 4);
        peek(3, 4);
        chk("wb3_busy", 32'(bus.BUSYA), 32'h0);
        chk("wb3_cnt", 32'(bus.BUSY_CNT), 32'h1);
        cycle(1, 1, 9, 32'h55, 0, 0, 0, 1, 9, 9, 9);
        peek(9, 9);
        chk("r9_data", bus.OUTA, 32'h55);
        chk("r9_busy", 32'(bus.BUSYA), 32'h1);
        chk("r9_cnt", 32'(bus.BUSY_CNT), 32'h2);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
        peek(0, 9);
        chk("issue0_cnt", 32'(bus.BUSY_CNT), 32'h2);
        chk("issue0_busy", 32'(bus.BUSYA), 32'h0);
        cycle(1, 1, 12, 32'h1111, 0, 0, 0, 0, 0, 12, 12);
        @(negedge CLK);
        bus.WEA = 0; bus.WEB = 1; bus.WAB = 12; bus.INB = 32'hA5A5A5A5;
        bus.ISSUE = 0; bus.RAA = 12; bus.RAB = 12;
        #1;
`ifdef REGFILE_SB_FWD_EN
        chk("fwd_same_cycle", bus.OUTA, 32'hA5A5A5A5);
`else
        chk("nofwd_same_cycle", bus.OUTA, 32'h1111);
`endif
        @(posedge CLK);
        m_reg[12] = 32'hA5A5A5A5;
        m_busy[12] = 1'b0;
        peek(12, 12);
        chk("r12_next_cycle", bus.OUTA, 32'hA5A5A5A5);
        for (int k = 0; k < 10000; k++) begin
            logic [4:0] waa, wab, isa, raa, rab;
            waa = 5'($urandom_range(0, 31));
            wab = ($urandom_range(0, 3) == 0) ? waa : 5'($urandom_range(0, 31));
            isa = ($urandom_range(0, 3) == 0) ? wab : 5'($urandom_range(0, 31));
            raa = ($urandom_range(0, 2) == 0) ? wab : 5'($urandom_range(0, 31));
            rab = ($urandom_range(0, 2) == 0) ? waa : 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 199) != 0,
                  1'($urandom_range(0, 1)), waa, $urandom,
                  1'($urandom_range(0, 1)), wab, $urandom,
                  1'($urandom_range(0, 1)), isa, raa, rab);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
